seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Time-multiplexed 6-digit seven-segment scan driver. It sits downstream of the clock/alarm controllers and the display mux. It takes the six BCD digits currently selected for display (time or alarm), plus mode and position, and drives one shared segment bus and six digit enables. It adds anti-ghosting blanking between digits, frame-coherent digit snapshots, blinking of the digit being edited, and optional hour leading-zero blanking.

Parameters:
SLOT_CYCLES, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); must be ≥ BLANK_CYCLES+2
BLANK_CYCLES, 500, cycles at slot start with all digits off
HOUR_LZB, 1, 1 = blank hour-tens digit when it is 0 in normal mode

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
sec_ones  input  4  digit slot 0
sec_tens  input  3  digit slot 1
min_ones  input  4  digit slot 2
min_tens  input  3  digit slot 3
hour_ones  input  4  digit slot 4
hour_tens  input  2  digit slot 5
mode  input  2  00 normal, 01 set clock, 10 set alarm, 11 treated as normal
pos  input  3  edit position; 1..6 selects slot 0..5; 0 and 7 select none
blink  input  1  blink phase level (2 Hz square); 0 = edited digit dark
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
dig_sel  output  6  digit enables, active-low, one-hot or all-ones
frame_start  output  1  one-cycle pulse when the snapshot is taken

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values: seg=0, dig_sel=6'b111111, frame_start=0, slot index idx=0, slot counter cnt=0, snapshot registers=0, state BLANK.
- Counter and index:
  - cnt counts 0..SLOT_CYCLES-1, then wraps to 0.
  - On wrap, idx advances 0→1→…→5→0.
- States (function of cnt):
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while BLANK_CYCLES ≤ cnt ≤ SLOT_CYCLES-1.
- Outputs are registered: they reflect the state/cnt/idx value of the previous cycle, so there is 1 cycle of latency.
  - BLANK: dig_sel=all ones, seg=0.
  - SHOW: dig_sel[idx]=0, others 1; seg = encoding of snapshot digit idx.
- Snapshot:
  - When cnt wraps and idx goes 5→0 (and on the first cycle after reset release), all six inputs are latched together.
  - frame_start pulses in that cycle.
  - Inputs changing mid-frame never mix old and new digits within one frame.
- Encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any value >9 shows a dash, 40.
- Narrow inputs (3-bit, 2-bit) are zero-extended to 4 bits before encoding.
- Blink: if mode∈{01,10}, pos∈1..6, pos-1==idx and blink==0, then seg=0 for that slot; dig_sel still toggles normally. The blink input is sampled live, not snapshotted.
- Alarm mode: when mode==10, slots 0 and 1 (seconds) show blank (seg=0), because the alarm has no seconds.
- Leading-zero blanking: if HOUR_LZB and mode∈{00,11} and snapshot hour_tens==0, slot 5 shows seg=0. Edit modes never apply LZB.
- Priority for seg in SHOW: alarm-seconds blank > blink blank > LZB > encoding.
- Reset mid-slot: the next cycle returns to the reset values; scanning restarts at idx 0, BLANK.
- Never two digits enabled; dig_sel is all ones for ≥ BLANK_CYCLES cycles at every digit change.

Decomposition:
- Shared package:
  - mode encodings MODE_NORMAL / MODE_SET_CLK / MODE_SET_ALM.
  - POS_NONE and the pos-to-slot mapping.
  - 7-segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit to 7-bit encoder, reusable by other display blocks.
- Counter, snapshot and state logic stay in the top.

Test Plan:
1. SLOT_CYCLES=10, BLANK_CYCLES=2, digits 5,4,3,2,1,1 (11:23:45), mode 00, held. Required response:
   - rst_n low 3 cycles, then high.
   - dig_sel=3F for 3 cycles after release, then 3E with seg=6D for 8 cycles.
   - Then 3F for 2 cycles, then 3D with seg=66.
   - frame_start pulses once per 60 cycles.
2. hour_tens=0, HOUR_LZB=1, mode 00 → slot 5 seg=00. Same with mode 01 → seg=3F.
3. mode 01, pos=3, blink=0 → slot 2 seg=00 while dig_sel=3B. blink=1 → seg shows min_ones encoding. Other slots are unaffected.
4. Change min_ones from 3 to 7 while idx=1. Required response:
   - Slot 2 still shows 4F in the current frame.
   - Slot 2 shows 07 after the next frame_start.
5. min_ones=4'hC → slot 2 seg=40. mode 10 → slots 0 and 1 seg=00.
6. Assert rst_n low during SHOW of slot 3 → next cycle seg=00, dig_sel=3F, idx=0. Over the full run, assert dig_sel never has two zero bits.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver and related display blocks:
// mode codes, edit-position mapping and segment patterns.
package seg_scan_driver_pkg;

    localparam logic [1:0] MODE_NORMAL  = 2'b00;
    localparam logic [1:0] MODE_SET_CLK = 2'b01;
    localparam logic [1:0] MODE_SET_ALM = 2'b10;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] POS_NONE = 3'd0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Positions 1..6 address slots 0..5; 0 and 7 address nothing.
    function automatic logic pos_valid(input logic [2:0] p);
        return (p >= 3'd1) && (p <= 3'd6);
    endfunction

    function automatic logic [2:0] pos_to_slot(input logic [2:0] p);
        return p - 3'd1;
    endfunction

    function automatic logic is_edit_mode(input logic [1:0] m);
        return (m == MODE_SET_CLK) || (m == MODE_SET_ALM);
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment encoder; non-decimal codes show a dash.
module bcd_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with inter-digit blanking,
// per-frame digit snapshots, edit-digit blinking and hour leading-zero blanking.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int HOUR_LZB     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_ones,
    input  logic [2:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [2:0] min_tens,
    input  logic [3:0] hour_ones,
    input  logic [1:0] hour_tens,
    input  logic [1:0] mode,
    input  logic [2:0] pos,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_start
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    scan_state_t     state_reg, state_next;
    logic [23:0]     snap_reg, snap_next;
    logic            first_reg;
    logic [6:0]      seg_reg, seg_next;
    logic [5:0]      dig_sel_reg, dig_sel_next;
    logic            frame_start_reg;

    logic            wrap;
    logic            take_snap;
    logic [23:0]     live_digits;
    logic [3:0]      snap_digit [NUM_DIGITS];
    logic [5:0]      slot_dig_sel;
    logic [3:0]      cur_digit;
    logic [6:0]      enc_seg;
    logic            alarm_blank, blink_blank, lzb_blank;

    // Narrow fields are zero-extended so every slot is a uniform 4-bit code.
    assign live_digits = {2'b00, hour_tens, hour_ones,
                          1'b0,  min_tens,  min_ones,
                          1'b0,  sec_tens,  sec_ones};

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign snap_digit[gi]   = snap_reg[4*gi +: 4];
            assign slot_dig_sel[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    always_comb begin
        cur_digit = 4'd0;
        case (idx_reg)
            3'd0: cur_digit = snap_digit[0];
            3'd1: cur_digit = snap_digit[1];
            3'd2: cur_digit = snap_digit[2];
            3'd3: cur_digit = snap_digit[3];
            3'd4: cur_digit = snap_digit[4];
            3'd5: cur_digit = snap_digit[5];
            default: cur_digit = 4'd0;
        endcase
    end

    bcd_to_seg7 u_enc (
        .bcd (cur_digit),
        .seg (enc_seg)
    );

    // Counter, slot index, snapshot and scan state.
    always_comb begin
        wrap       = (cnt_reg == CNT_LAST);
        cnt_next   = wrap ? '0 : cnt_reg + 1'b1;
        idx_next   = idx_reg;
        if (wrap) begin
            idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        end
        take_snap  = first_reg || (wrap && (idx_reg == IDX_LAST));
        snap_next  = take_snap ? live_digits : snap_reg;
        state_next = (cnt_next < BLANK_END) ? ST_BLANK : ST_SHOW;
    end

    // Blink and mode come in live; only the digits are frame-coherent.
    always_comb begin
        alarm_blank = (mode == MODE_SET_ALM) && (idx_reg < 3'd2);
        blink_blank = is_edit_mode(mode) && pos_valid(pos) &&
                      (pos_to_slot(pos) == idx_reg) && !blink;
        lzb_blank   = (HOUR_LZB != 0) && !is_edit_mode(mode) &&
                      (idx_reg == IDX_LAST) && (snap_digit[5] == 4'd0);

        seg_next     = SEG_OFF;
        dig_sel_next = 6'b111111;
        if (state_reg == ST_SHOW) begin
            dig_sel_next = slot_dig_sel;
            if (alarm_blank || blink_blank || lzb_blank) begin
                seg_next = SEG_OFF;
            end else begin
                seg_next = enc_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            idx_reg         <= 3'd0;
            state_reg       <= ST_BLANK;
            snap_reg        <= '0;
            first_reg       <= 1'b1;
            seg_reg         <= SEG_OFF;
            dig_sel_reg     <= 6'b111111;
            frame_start_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            state_reg       <= state_next;
            snap_reg        <= snap_next;
            first_reg       <= 1'b0;
            seg_reg         <= seg_next;
            dig_sel_reg     <= dig_sel_next;
            frame_start_reg <= take_snap;
        end
    end

    assign seg         = seg_reg;
    assign dig_sel     = dig_sel_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with a short slot (10 cycles, 2 blank).
module tb_seg_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hour_ones;
    logic [1:0] hour_tens;
    logic [1:0] mode;
    logic [2:0] pos;
    logic       blink;
    logic [6:0] seg;
    logic [5:0] dig_sel;
    logic       frame_start;

    seg_scan_driver #(
        .SLOT_CYCLES  (10),
        .BLANK_CYCLES (2),
        .HOUR_LZB     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .hour_ones   (hour_ones),
        .hour_tens   (hour_tens),
        .mode        (mode),
        .pos         (pos),
        .blink       (blink),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row: scenario, cycle after release, inputs applied before that edge, expected outputs.
    typedef struct {
        int         sc;
        int         t;
        logic [19:0] digits;
        logic [1:0] m;
        logic [2:0] p;
        logic       b;
        logic [5:0] dig;
        logic [6:0] sg;
        logic       fs;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   cur_t;
    int   fs_count;

    // Packing: {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}
    function automatic logic [19:0] mk(input int ht, input int ho, input int mt,
                                       input int mo, input int st, input int so);
        return {2'(ht), 4'(ho), 3'(mt), 4'(mo), 3'(st), 4'(so)};
    endfunction

    task automatic add(input int sc, input int t, input logic [19:0] d,
                       input logic [1:0] m, input logic [2:0] p, input logic b,
                       input logic [5:0] dg, input logic [6:0] sg, input logic fs);
        vec_t v;
        v.sc = sc; v.t = t; v.digits = d; v.m = m; v.p = p; v.b = b;
        v.dig = dg; v.sg = sg; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h required=%h", nm, t, act, exp);
        end
    endtask

    task automatic apply_digits(input logic [19:0] d);
        {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} = d;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cur_t++;
        if (frame_start === 1'b1) fs_count++;
        checks++;
        if ($countones(~dig_sel) > 1) begin
            errors++;
            $display("FAIL onehot t=%0d got=%h required=at most one low bit", cur_t, dig_sel);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 0, 32'(seg), 32'h00);
        chk("rst_dig_sel", 0, 32'(dig_sel), 32'h3F);
        chk("rst_frame_start", 0, 32'(frame_start), 32'h0);
        rst_n    = 1'b1;
        cur_t    = 0;
        fs_count = 0;
    endtask

    initial begin
        logic [19:0] d0, d1, d3, d4;
        checks = 0; errors = 0; cur_t = 0; fs_count = 0;
        rst_n = 1'b0; mode = 2'b00; pos = 3'd0; blink = 1'b1;
        d0 = mk(1, 1, 2, 3, 4, 5);
        d1 = mk(0, 1, 2, 3, 4, 5);
        d3 = mk(1, 1, 2, 7, 4, 5);
        d4 = mk(3, 1, 2, 12, 7, 5);
        apply_digits(d0);

        // Basic scan of 11:23:45 and frame pulses
        add(0,   1, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b1);
        add(0,   2, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b0);
        add(0,   3, d0, 2'd0, 3'd0, 1'b1, 6'h3E, 7'h6D, 1'b0);
        add(0,  10, d0, 2'd0, 3'd0, 1'b1, 6'h3E, 7'h6D, 1'b0);
        add(0,  11, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b0);
        add(0,  12, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b0);
        add(0,  13, d0, 2'd0, 3'd0, 1'b1, 6'h3D, 7'h66, 1'b0);
        add(0,  23, d0, 2'd0, 3'd0, 1'b1, 6'h3B, 7'h4F, 1'b0);
        add(0,  33, d0, 2'd0, 3'd0, 1'b1, 6'h37, 7'h5B, 1'b0);
        add(0,  43, d0, 2'd0, 3'd0, 1'b1, 6'h2F, 7'h06, 1'b0);
        add(0,  53, d0, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h06, 1'b0);
        add(0,  60, d0, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h06, 1'b1);
        add(0,  61, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b0);
        add(0,  63, d0, 2'd0, 3'd0, 1'b1, 6'h3E, 7'h6D, 1'b0);
        add(0, 120, d0, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h06, 1'b1);
        // Hour leading-zero blanking
        add(1,   1, d1, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b1);
        add(1,  43, d1, 2'd0, 3'd0, 1'b1, 6'h2F, 7'h06, 1'b0);
        add(1,  53, d1, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h00, 1'b0);
        add(1,  54, d1, 2'd1, 3'd0, 1'b1, 6'h1F, 7'h3F, 1'b0);
        add(1,  55, d1, 2'd3, 3'd0, 1'b1, 6'h1F, 7'h00, 1'b0);
        add(1,  56, d1, 2'd1, 3'd6, 1'b0, 6'h1F, 7'h00, 1'b0);
        add(1,  57, d1, 2'd1, 3'd6, 1'b1, 6'h1F, 7'h3F, 1'b0);
        // Blinking of the edited digit
        add(2,   1, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b1);
        add(2,  13, d0, 2'd1, 3'd3, 1'b0, 6'h3D, 7'h66, 1'b0);
        add(2,  23, d0, 2'd1, 3'd3, 1'b0, 6'h3B, 7'h00, 1'b0);
        add(2,  24, d0, 2'd1, 3'd3, 1'b1, 6'h3B, 7'h4F, 1'b0);
        add(2,  25, d0, 2'd1, 3'd3, 1'b0, 6'h3B, 7'h00, 1'b0);
        add(2,  26, d0, 2'd2, 3'd3, 1'b0, 6'h3B, 7'h00, 1'b0);
        add(2,  27, d0, 2'd1, 3'd0, 1'b0, 6'h3B, 7'h4F, 1'b0);
        add(2,  28, d0, 2'd1, 3'd7, 1'b0, 6'h3B, 7'h4F, 1'b0);
        add(2,  29, d0, 2'd0, 3'd3, 1'b0, 6'h3B, 7'h4F, 1'b0);
        add(2,  33, d0, 2'd1, 3'd3, 1'b0, 6'h37, 7'h5B, 1'b0);
        // Frame-coherent snapshot
        add(3,   1, d0, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b1);
        add(3,  12, d3, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b0);
        add(3,  23, d3, 2'd0, 3'd0, 1'b1, 6'h3B, 7'h4F, 1'b0);
        add(3,  60, d3, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h06, 1'b1);
        add(3,  83, d3, 2'd0, 3'd0, 1'b1, 6'h3B, 7'h07, 1'b0);
        // Dash, alarm-mode seconds blank, zero extension
        add(4,   1, d4, 2'd0, 3'd0, 1'b1, 6'h3F, 7'h00, 1'b1);
        add(4,   3, d4, 2'd2, 3'd0, 1'b1, 6'h3E, 7'h00, 1'b0);
        add(4,   4, d4, 2'd0, 3'd0, 1'b1, 6'h3E, 7'h6D, 1'b0);
        add(4,  13, d4, 2'd2, 3'd0, 1'b1, 6'h3D, 7'h00, 1'b0);
        add(4,  14, d4, 2'd0, 3'd0, 1'b1, 6'h3D, 7'h07, 1'b0);
        add(4,  23, d4, 2'd2, 3'd0, 1'b1, 6'h3B, 7'h40, 1'b0);
        add(4,  24, d4, 2'd0, 3'd0, 1'b1, 6'h3B, 7'h40, 1'b0);
        add(4,  53, d4, 2'd0, 3'd0, 1'b1, 6'h1F, 7'h4F, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].sc != vecs[i-1].sc) begin
                if (i > 0 && vecs[i-1].sc == 0) begin
                    chk("frame_count", cur_t, 32'(fs_count), 32'd3);
                end
                mode = 2'b00; pos = 3'd0; blink = 1'b1;
                do_reset();
            end
            while (cur_t < vecs[i].t - 1) step();
            apply_digits(vecs[i].digits);
            mode  = vecs[i].m;
            pos   = vecs[i].p;
            blink = vecs[i].b;
            step();
            chk($sformatf("row%0d_dig_sel", i), cur_t, 32'(dig_sel), 32'(vecs[i].dig));
            chk($sformatf("row%0d_seg", i), cur_t, 32'(seg), 32'(vecs[i].sg));
            chk($sformatf("row%0d_frame_start", i), cur_t, 32'(frame_start), 32'(vecs[i].fs));
        end

        // Reset asserted while slot 3 is lit
        apply_digits(d0);
        mode = 2'b00; pos = 3'd0; blink = 1'b1;
        do_reset();
        while (cur_t < 33) step();
        chk("pre_rst_dig_sel", cur_t, 32'(dig_sel), 32'h37);
        chk("pre_rst_seg", cur_t, 32'(seg), 32'h5B);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_seg", 0, 32'(seg), 32'h00);
        chk("midrst_dig_sel", 0, 32'(dig_sel), 32'h3F);
        chk("midrst_frame_start", 0, 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        cur_t = 0;
        step();
        chk("restart_frame_start", cur_t, 32'(frame_start), 32'h1);
        step();
        chk("restart_blank", cur_t, 32'(dig_sel), 32'h3F);
        step();
        chk("restart_idx0_dig_sel", cur_t, 32'(dig_sel), 32'h3E);
        chk("restart_idx0_seg", cur_t, 32'(seg), 32'h6D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0d got=running required=finished", cur_t);
        $fatal(1, "timeout");
    end

endmodule
